input_keypad: RTL

INPUT_KEYPAD -- requirements
Module: input_keypad

---
 rtl/input_keypad_pkg.sv | 37 +++
 rtl/input_keypad_encoder.sv | 34 +++
 rtl/input_keypad.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/input_keypad_pkg.sv
// Shared definitions for the keypad front end: command codes, payload
// widths and the debounce state encoding.

`ifndef INPUT_INTERFACE_V
`define INPUT_INTERFACE_V
`define ID_N    4
`define IC_N    3
`define IC_NONE 3'd0
`define IC_NUM  3'd1
`define IC_OP   3'd2
`define IC_EQU  3'd3
`define IC_CLR  3'd4
`endif

package input_keypad_pkg;

  localparam int ID_N = `ID_N;
  localparam int IC_N = `IC_N;

  // Key event command toward the calculator core.
  typedef enum logic [IC_N-1:0] {
    IC_NONE = `IC_NONE,
    IC_NUM  = `IC_NUM,
    IC_OP   = `IC_OP,
    IC_EQU  = `IC_EQU,
    IC_CLR  = `IC_CLR
  } ic_e;

  // Debounce state machine states.
  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_DEB_PRESS,
    ST_PRESSED,
    ST_DEB_RELEASE
  } deb_state_e;

endpackage

// File: rtl/input_keypad_encoder.sv
// Combinational map from a 4x4 key index (4*row + col) to a calculator
// command and payload.

module input_keypad_encoder
  import input_keypad_pkg::*;
(
  input  logic [3:0]      i_key,
  output ic_e             o_cmd,
  output logic [ID_N-1:0] o_data
);

  // Decode the key index; the digit pads follow a 3-wide phone layout.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    o_cmd  = IC_NONE;
    o_data = '0;
    case (i_key)
      4'd3:  begin o_cmd = IC_OP;  o_data = 4'd0; end
      4'd7:  begin o_cmd = IC_OP;  o_data = 4'd1; end
      4'd11: begin o_cmd = IC_OP;  o_data = 4'd2; end
      4'd15: begin o_cmd = IC_OP;  o_data = 4'd3; end
      4'd12: begin o_cmd = IC_CLR; o_data = 4'd0; end
      4'd13: begin o_cmd = IC_NUM; o_data = 4'd0; end
      4'd14: begin o_cmd = IC_EQU; o_data = 4'd0; end
      default: begin
        // Rows 0..2, columns 0..2 carry digits 1..9 as row*3 + col + 1.
        o_cmd  = IC_NUM;
        o_data = ({2'b00, i_key[3:2]} * 4'd3) + {2'b00, i_key[1:0]} + 4'd1;
      end
    endcase
  end

endmodule

// File: rtl/input_keypad.sv
// 4x4 matrix keypad scanner: synchronises the row lines, walks an
// active-low column strobe, classifies each full frame, debounces over
// DEB_FRAMES frames and emits a single-cycle command per accepted press.

module input_keypad
  import input_keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [0:3]      ROW,
  output logic [0:3]      COL,
  output logic [ID_N-1:0] data,
  output logic [IC_N-1:0] cmd
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N      = CW'(DEB_FRAMES);

  logic [0:3]    r_row_s1, r_row_s2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [1:0]    r_hits;       // contacts so far this frame, saturates at 2
  logic [3:0]    r_key;        // index of the last contact seen this frame
  deb_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt, w_count_inc;
  logic [3:0]    r_cand, w_cand_nxt;
  ic_e           r_cmd, w_enc_cmd;
  logic [ID_N-1:0] r_data, w_enc_data;

  logic          w_dwell_last, w_frame_end, w_emit, w_frame_key;
  logic [2:0]    w_col_hits, w_sum;
  logic [3:0]    w_col_key, w_key_tot;
  logic [1:0]    w_hits_tot;

  // Two-flop synchroniser for the asynchronous row inputs (idle = pulled up).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_row_s1 <= 4'b1111;
      r_row_s2 <= 4'b1111;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the old
      // values together, giving a true two-stage pipeline.
      r_row_s1 <= ROW;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_dwell_last = (r_dwell == DWELL_LAST);
  assign w_frame_end  = w_dwell_last && (r_col == 2'd3);

  // Column dwell timer; the 2-bit column index wraps 3 -> 0 on its own.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_dwell <= '0;
      r_col   <= 2'd0;
    end else if (w_dwell_last) begin
      r_dwell <= '0;
      r_col   <= r_col + 2'd1;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  // Drive exactly one column low.
  always_comb begin
    COL        = 4'b1111;
    COL[r_col] = 1'b0;
  end

  // Contacts seen on the currently driven column.
  always_comb begin
    w_col_hits = 3'd0;
    w_col_key  = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (!r_row_s2[r]) begin
        w_col_hits = w_col_hits + 3'd1;
        w_col_key  = {r[1:0], r_col};
      end
    end
  end

  assign w_sum       = {1'b0, r_hits} + w_col_hits;
  assign w_hits_tot  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_key_tot   = (w_col_hits != 3'd0) ? w_col_key : r_key;
  // A MULTI frame is indistinguishable from NONE to the debouncer.
  assign w_frame_key = (w_hits_tot == 2'd1);
  assign w_count_inc = r_count + 1'b1;

  // Per-frame contact accumulator, cleared as each frame is handed over.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_hits <= 2'd0;
      r_key  <= 4'd0;
    end else if (w_frame_end) begin
      r_hits <= 2'd0;
      r_key  <= 4'd0;
    end else if (w_dwell_last) begin
      r_hits <= w_hits_tot;
      r_key  <= w_key_tot;
    end
  end

  // Debounce next-state logic, evaluated once per completed frame.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_cand_nxt  = r_cand;
    w_emit      = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        ST_RELEASED: begin
          if (w_frame_key) begin
            w_cand_nxt  = w_key_tot;
            w_count_nxt = CW'(1);
            if (DEB_FRAMES == 1) begin
              w_state_nxt = ST_PRESSED;
              w_emit      = 1'b1;
            end else begin
              w_state_nxt = ST_DEB_PRESS;
            end
          end
        end
        ST_DEB_PRESS: begin
          if (w_frame_key && (w_key_tot == r_cand)) begin
            w_count_nxt = w_count_inc;
            if (w_count_inc == DEB_N) begin
              w_state_nxt = ST_PRESSED;
              w_emit      = 1'b1;
            end
          end else if (w_frame_key) begin
            w_cand_nxt  = w_key_tot;
            w_count_nxt = CW'(1);
          end else begin
            w_state_nxt = ST_RELEASED;
            w_count_nxt = '0;
          end
        end
        ST_PRESSED: begin
          if (!w_frame_key) begin
            if (DEB_FRAMES == 1) begin
              w_state_nxt = ST_RELEASED;
              w_count_nxt = '0;
            end else begin
              w_state_nxt = ST_DEB_RELEASE;
              w_count_nxt = CW'(1);
            end
          end
        end
        ST_DEB_RELEASE: begin
          if (w_frame_key) begin
            w_state_nxt = ST_PRESSED;
          end else begin
            w_count_nxt = w_count_inc;
            if (w_count_inc == DEB_N) begin
              w_state_nxt = ST_RELEASED;
              w_count_nxt = '0;
            end
          end
        end
        default: w_state_nxt = ST_RELEASED;
      endcase
    end
  end

  // Debounce state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_RELEASED;
      r_count <= '0;
      r_cand  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  input_keypad_encoder u_encoder (
    .i_key  (w_key_tot),
    .o_cmd  (w_enc_cmd),
    .o_data (w_enc_data)
  );

  // Registered single-cycle event output; idle value is NONE with zero data.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cmd  <= IC_NONE;
      r_data <= '0;
    end else if (w_emit) begin
      r_cmd  <= w_enc_cmd;
      r_data <= w_enc_data;
    end else begin
      r_cmd  <= IC_NONE;
      r_data <= '0;
    end
  end

  assign cmd  = r_cmd;
  assign data = r_data;

endmodule
